// File: rtl/nrx_sprite_linebuf.sv
// rtl/nrx_sprite_linebuf.sv - double-banked sprite line buffer with read-and-erase
// The reader scans bank SIDE while the renderer fills bank ~SIDE; each bank is single-port.
module nrx_sprite_linebuf #(
    parameter int AW = 9,
    parameter int DW = 9
) (
    input  logic          VCLKx4,
    input  logic          RESET,
    input  logic          PIX_EN,
    input  logic          SIDE,
    input  logic [AW-1:0] HPOS,
    input  logic          WEN,
    input  logic [AW-1:0] WADR,
    input  logic [DW-1:0] WDAT,
    output logic [DW-1:0] SPCOL,
    output logic          BUSY,
    output logic          WDROP
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    logic          p1_q, p2_q;
    logic          rb_q;
    logic [AW-1:0] ra_q;
    logic [DW-1:0] spcol_q;
    logic          wdrop_q, wdrop_d;

    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] rd0_q, rd1_q;

    logic          run;
    logic          rd_go, er_go, wr_req, wr_bank, wr_block, wr_go;
    logic [1:0]    bank_we, bank_re;
    logic [AW-1:0] bank_addr  [2];
    logic [DW-1:0] bank_wdata [2];
    logic [DW-1:0] rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Reset also blocks bank traffic on the edge it is first sampled, so a pending erase is dropped.
    always_comb begin
        run      = (state_q == ST_RUN) && !RESET;
        rd_go    = run && PIX_EN;
        er_go    = run && p2_q;
        wr_req   = run && WEN && (WDAT[1:0] != 2'b00);
        wr_bank  = ~SIDE;
        wr_block = (er_go && (rb_q == wr_bank)) || (rd_go && (SIDE == wr_bank));
        wr_go    = wr_req && !wr_block;
        wdrop_d  = wr_req && wr_block;
    end

    // Per-bank port arbitration: sweep, then read, then erase, then renderer store.
    always_comb begin
        bank_we = 2'b00;
        bank_re = 2'b00;
        for (int b = 0; b < 2; b++) begin
            bank_addr[b]  = '0;
            bank_wdata[b] = '0;
            if (state_q == ST_CLEAR) begin
                bank_we[b]   = 1'b1;
                bank_addr[b] = cnt_q;
            end else if (rd_go && (SIDE == b[0])) begin
                bank_re[b]   = 1'b1;
                bank_addr[b] = HPOS;
            end else if (er_go && (rb_q == b[0])) begin
                bank_we[b]   = 1'b1;
                bank_addr[b] = ra_q;
            end else if (wr_go && (wr_bank == b[0])) begin
                bank_we[b]    = 1'b1;
                bank_addr[b]  = WADR;
                bank_wdata[b] = WDAT;
            end
        end
    end

    always_ff @(posedge VCLKx4) begin
        if (bank_we[0]) begin
            mem0[bank_addr[0]] <= bank_wdata[0];
        end
        if (bank_re[0]) begin
            rd0_q <= mem0[bank_addr[0]];
        end
        if (bank_we[1]) begin
            mem1[bank_addr[1]] <= bank_wdata[1];
        end
        if (bank_re[1]) begin
            rd1_q <= mem1[bank_addr[1]];
        end
    end

    assign rdata = rb_q ? rd1_q : rd0_q;

    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            p1_q    <= 1'b0;
            p2_q    <= 1'b0;
            rb_q    <= 1'b0;
            ra_q    <= '0;
            spcol_q <= '0;
            wdrop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p1_q    <= rd_go;
            p2_q    <= p1_q;
            if (rd_go) begin
                rb_q <= SIDE;
                ra_q <= HPOS;
            end
            if (p1_q) begin
                spcol_q <= rdata;
            end
            wdrop_q <= wdrop_d;
        end
    end

    assign SPCOL = spcol_q;
    assign BUSY  = (state_q == ST_CLEAR);
    assign WDROP = wdrop_q;

endmodule

// File: tb/tb_nrx_sprite_linebuf.sv
// tb/tb_nrx_sprite_linebuf.sv - bench for nrx_sprite_linebuf against a read-and-erase bank model
module tb_nrx_sprite_linebuf;

    logic       clk = 1'b0;
    logic       rst, pix_en, side, wen;
    logic [8:0] hpos, wadr, wdat;
    logic [8:0] spcol;
    logic       busy, wdrop;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] model [0:1][0:511];
    logic [8:0] last_spcol;

    nrx_sprite_linebuf #(.AW(9), .DW(9)) dut (
        .VCLKx4 (clk),
        .RESET  (rst),
        .PIX_EN (pix_en),
        .SIDE   (side),
        .HPOS   (hpos),
        .WEN    (wen),
        .WADR   (wadr),
        .WDAT   (wdat),
        .SPCOL  (spcol),
        .BUSY   (busy),
        .WDROP  (wdrop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 512; i++)
                model[b][i] = 9'h000;
        last_spcol = 9'h000;
    endtask

    task automatic set_side(input logic s);
        side = s;
        tick();
    endtask

    task automatic wr(input logic [8:0] a, input logic [8:0] d);
        wen = 1'b1; wadr = a; wdat = d;
        tick();
        wen = 1'b0;
        n_checks++;
        if (wdrop !== 1'b0) $display("FAIL wdrop_on_write adr=%0d got=%b exp=0", a, wdrop);
        else n_pass++;
        if (d[1:0] != 2'b00) model[~side][a] = d;
        tick();
    endtask

    task automatic pix_read(input logic [8:0] x);
        logic [8:0] exp;
        exp = model[side][x];
        model[side][x] = 9'h000;
        pix_en = 1'b1; hpos = x;
        tick();
        pix_en = 1'b0;
        n_checks++;
        if (spcol !== last_spcol) $display("FAIL spcol_early x=%0d got=%h exp=%h", x, spcol, last_spcol);
        else n_pass++;
        tick();
        n_checks++;
        if (spcol !== exp) $display("FAIL spcol side=%0d x=%0d got=%h exp=%h", side, x, spcol, exp);
        else n_pass++;
        last_spcol = exp;
        tick();
        tick();
    endtask

    task automatic reset_sweep(input int hold);
        int  cnt;
        bit  spcol_bad;
        rst = 1'b1;
        for (int i = 0; i < hold; i++) tick();
        rst = 1'b0;
        cnt = 0;
        spcol_bad = 1'b0;
        while (busy === 1'b1 && cnt < 600) begin
            cnt++;
            if (spcol !== 9'h000) spcol_bad = 1'b1;
            if (cnt == 300) begin
                wen = 1'b1; wadr = 9'd10; wdat = 9'h1A7;
            end else begin
                wen = 1'b0;
            end
            tick();
        end
        wen = 1'b0;
        n_checks++;
        if (cnt != 512) $display("FAIL busy_len got=%0d exp=512", cnt);
        else n_pass++;
        n_checks++;
        if (spcol_bad) $display("FAIL spcol_during_sweep got=nonzero exp=0");
        else n_pass++;
        clear_model();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (spcol !== 9'h000 || busy !== 1'b1 || wdrop !== 1'b0)
            $display("FAIL reset_state got spcol=%h busy=%b wdrop=%b exp 000/1/0", spcol, busy, wdrop);
        else n_pass++;
        reset_sweep(2);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL busy_after_sweep got=%b exp=0", busy);
        else n_pass++;
        set_side(1'b1);
        pix_read(9'd10);
        pix_read(9'd0);
        pix_read(9'd511);
        set_side(1'b0);
        pix_read(9'd10);
        pix_read(9'd511);
    endtask

    task automatic test_basic();
        set_side(1'b0);
        wr(9'd37, 9'h1A5);
        set_side(1'b1);
        n_checks++;
        if (model[1][37] !== 9'h1A5) $display("FAIL basic_model got=%h exp=1a5", model[1][37]);
        else n_pass++;
        pix_read(9'd37);
        set_side(1'b0);
        set_side(1'b1);
        pix_read(9'd37);
    endtask

    task automatic test_transparency();
        set_side(1'b0);
        wr(9'd100, 9'h0F3);
        wr(9'd100, 9'h1FC);
        wr(9'd101, 9'h046);
        wr(9'd101, 9'h047);
        set_side(1'b1);
        pix_read(9'd100);
        pix_read(9'd101);
    endtask

    task automatic test_wrap();
        set_side(1'b1);
        wr(9'd511, 9'h155);
        wr(9'd0, 9'h0AA);
        set_side(1'b0);
        pix_read(9'd511);
        pix_read(9'd0);
    endtask

    task automatic test_conflict();
        logic [8:0] exp;
        set_side(1'b1);
        wr(9'd5, 9'h0D1);
        wr(9'd9, 9'h0B2);
        set_side(1'b0);
        exp = model[0][5];
        model[0][5] = 9'h000;
        pix_en = 1'b1; hpos = 9'd5;
        tick();
        pix_en = 1'b0;
        side = 1'b1;
        tick();
        n_checks++;
        if (spcol !== exp) $display("FAIL conflict_spcol got=%h exp=%h", spcol, exp);
        else n_pass++;
        last_spcol = exp;
        wen = 1'b1; wadr = 9'd9; wdat = 9'h0C3;
        tick();
        wen = 1'b0;
        n_checks++;
        if (wdrop !== 1'b1) $display("FAIL conflict_wdrop got=%b exp=1", wdrop);
        else n_pass++;
        tick();
        n_checks++;
        if (wdrop !== 1'b0) $display("FAIL conflict_wdrop_len got=%b exp=0", wdrop);
        else n_pass++;
        set_side(1'b0);
        pix_read(9'd9);
        pix_read(9'd5);
    endtask

    task automatic test_random();
        int         r;
        logic [8:0] a;
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) == 1) ? 9'd511 : 9'd0;
            else a = 9'($urandom_range(0, 15));
            if (r < 2) set_side(~side);
            else if (r < 6) wr(a, 9'($urandom_range(0, 511)));
            else pix_read(a);
        end
    endtask

    task automatic test_reset_mid();
        set_side(1'b0);
        wr(9'd200, 9'h1ED);
        wr(9'd300, 9'h0E2);
        set_side(1'b1);
        wr(9'd300, 9'h0F1);
        pix_en = 1'b1; hpos = 9'd200;
        tick();
        pix_en = 1'b0;
        rst = 1'b1;
        tick();
        n_checks++;
        if (spcol !== 9'h000 || busy !== 1'b1)
            $display("FAIL reset_mid got spcol=%h busy=%b exp 000/1", spcol, busy);
        else n_pass++;
        reset_sweep(1);
        for (int b = 0; b < 2; b++) begin
            set_side(b[0]);
            for (int x = 0; x < 512; x++) pix_read(9'(x));
        end
    endtask

    initial begin
        rst = 1'b1; pix_en = 1'b0; side = 1'b0; wen = 1'b0;
        hpos = '0; wadr = '0; wdat = '0;
        clear_model();
        test_reset();
        test_basic();
        test_transparency();
        test_wrap();
        test_conflict();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nrx_sprite_linebuf.md
# nrx_sprite_linebuf

Double-banked sprite line buffer that sits between the sprite renderer (writer) and the video mixer (reader). The renderer deposits 9-bit sprite/radar-dot colour codes into the back bank during H-blank. The reader side scans the front bank in step with the beam, presents each dot as `SPCOL`, and erases it after reading so the bank is clean when it becomes the back bank on the next line. The banks swap on every change of `SIDE`, which is `VPOS[0]`.

## Interface
Parameters:
- `AW`, 9: pixel address width; each bank holds 2^AW entries.
- `DW`, 9: colour word width. Bits [1:0]=00 mean transparent.

Ports:
- `VCLKx4` in 1: the only clock. All logic is on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `PIX_EN` in 1: one-cycle strobe per pixel. Minimum spacing is 4 clocks.
- `SIDE` in 1: line parity. The reader uses bank `SIDE`; the writer uses bank `~SIDE`.
- `HPOS` in AW: beam X position, sampled on `PIX_EN`.
- `WEN` in 1: writer strobe. At most one per 2 clocks.
- `WADR` in AW: writer pixel address, i.e. X in the back bank.
- `WDAT` in DW: writer colour word.
- `SPCOL` out DW: sprite colour for the current pixel. Reset value 0.
- `BUSY` out 1: high while the clear sweep runs. Reset value 1.
- `WDROP` out 1: one-cycle pulse when a write is discarded. Reset value 0.

## Operation
State machine with two states, `CLEAR` and `RUN`:
- `RESET`=1 at any time, including mid-sweep or mid-pixel:
  - go to `CLEAR`;
  - sweep counter := 0;
  - abandon any pending read or clear;
  - `SPCOL`=0, `WDROP`=0.
- `CLEAR`:
  - each clock, write 0 to address `cnt` in both banks, then `cnt++`.
  - When `cnt`=2^AW−1 has been written, go to `RUN` on the next clock.
  - The sweep takes 2^AW clocks after `RESET` is released.
  - `BUSY`=1 throughout `CLEAR`.
  - `WEN` and `PIX_EN` are ignored.
- `RUN`: `BUSY`=0. Read, clear and write operate as follows.

Reader pipeline:
- P0, on the `PIX_EN` cycle: latch `rb`=`SIDE` and `ra`=`HPOS`. Issue a synchronous read of bank `rb` at address `ra`.
- P1: read data is returned. Load `SPCOL` with it.
- P2: write 0 to bank `rb`, address `ra` (read-and-erase).
- The pending erase always uses the bank and address latched at P0, even if `SIDE` or `HPOS` change during P1 or P2.

Writer:
- On a `WEN` cycle with `WDAT[1:0]`≠00, write `WDAT` into bank `~SIDE` at `WADR`, using the current `SIDE`.
- If `WDAT[1:0]`=00, nothing is written. The entry keeps its previous value and `WDROP` stays 0.
- Among overlapping sprite writes, the later write to an address wins. There is no read-modify-write.

Port conflict:
- Each bank is single-port. A conflict exists when a P2 erase and a writer store target the same bank in the same clock. This can only happen when `SIDE` toggles inside a pixel slot.
- On a conflict, the erase wins, the write is discarded, and `WDROP` pulses for 1 clock.
- A P0 read colliding with a write in the same bank follows the same rule: the read wins and `WDROP` pulses.

Address arithmetic:
- No wrap logic. `HPOS` and `WADR` index the bank modulo 2^AW, so address 511 followed by address 0 is legal.

## Timing
- `SPCOL` updates on the clock edge ending P1, i.e. 2 clocks after the `PIX_EN` edge. It holds until the next read completes.
- The erase lands 3 clocks after `PIX_EN`. It finishes before the next `PIX_EN` at the minimum 4-clock spacing.
- A write is visible to the reader after the `SIDE` toggle if the `WEN` edge precedes the toggle edge.
- `PIX_EN` arriving while a previous slot is still in P1 or P2 is a protocol violation. Behaviour is undefined; the bench must not stimulate it.
- `SPCOL`=0 from the first `RESET` edge until the first read completes after `BUSY` falls.

## Test plan
- Reset sweep: hold `RESET` 2 clocks, then release.
  - Required: `BUSY`=1 for exactly 512 clocks, then 0.
  - Required: reading any of X=0..511 on both banks returns 0.
- Basic path:
  - Stimulus: with `SIDE`=0, write 0x1A5 at X=37; toggle `SIDE` to 1; pulse `PIX_EN` with `HPOS`=37.
  - Required: `SPCOL`=0x1A5 exactly 2 clocks after `PIX_EN`.
  - Required: after 2 more `SIDE` toggles, reading X=37 gives 0, proving the erase.
- Transparency and overwrite:
  - Stimulus: write 0x0F3 at X=100, then 0x1FC at X=100 (the second is transparent, bits [1:0]=00), then 0x046 at X=101 followed by 0x047 at X=101.
  - Required: after the swap, X=100 reads 0x0F3 and X=101 reads 0x047.
- Wrap-around:
  - Stimulus: write to X=511 and X=0, swap, read X=511 then X=0.
  - Required: both values are returned in order with no aliasing.
- Bank conflict:
  - Stimulus: `PIX_EN` on bank 0 at X=5; toggle `SIDE` to 1 one clock later; assert `WEN` to X=9 so that it coincides with the P2 erase in bank 0.
  - Required: `WDROP`=1 for 1 clock, X=5 is erased, and X=9 is unchanged.
- Reset mid-operation:
  - Stimulus: assert `RESET` in the clock after `PIX_EN`, with `SPCOL` still pending.
  - Required: `SPCOL`=0, `BUSY`=1, no stale value appears, and the full 512-clock sweep restarts.
